// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler for the E stage.
// Owns the architectural HI and LO registers, launches the external multi-cycle
// mult/div unit, counts its latency, commits the result into HI/LO and generates
// the D-stage stall for HI/LO instructions while an operation is in flight.
// Optional feature macro: MD_DIV0_SKIP_EN (div/divu by zero becomes a no-op).
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op_type,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        d_is_md,
    input  logic [31:0] res_hi,
    input  logic [31:0] res_lo,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data
);

    // Counter holds LAT-1 down to 0; at least 4 bits wide.
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT) > 4) ? $clog2(MAX_LAT) : 4;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    // E-stage opcode encoding.
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    // Unit operation encoding.
    localparam logic [1:0] UOP_MULT  = 2'd0;
    localparam logic [1:0] UOP_MULTU = 2'd1;
    localparam logic [1:0] UOP_DIV   = 2'd2;
    localparam logic [1:0] UOP_DIVU  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic       is_mul;
    logic       is_div;
    logic       is_mthi;
    logic       is_mtlo;
    logic       is_mfhi;
    logic       is_mflo;
    logic [1:0] op_code;
    logic       div_skip;
    logic       start_now;

    // Decode the E-stage instruction; everything is qualified by op_valid here.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before the
        // case, otherwise the unassigned paths infer latches.
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        op_code = UOP_MULT;
        if (op_valid) begin
            case (op_type)
                OP_MULT:  begin is_mul = 1'b1; op_code = UOP_MULT;  end
                OP_MULTU: begin is_mul = 1'b1; op_code = UOP_MULTU; end
                OP_DIV:   begin is_div = 1'b1; op_code = UOP_DIV;   end
                OP_DIVU:  begin is_div = 1'b1; op_code = UOP_DIVU;  end
                OP_MTHI:  is_mthi = 1'b1;
                OP_MTLO:  is_mtlo = 1'b1;
                OP_MFHI:  is_mfhi = 1'b1;
                OP_MFLO:  is_mflo = 1'b1;
                default:  ;
            endcase
        end
    end

`ifdef MD_DIV0_SKIP_EN
    // A divide by zero is dropped here so the unit never sees it.
    assign div_skip = is_div & (op_b == 32'd0);
`else
    // Divide by zero runs like any other divide; op_b only matters to the unit.
    logic unused_op_b;
    assign div_skip    = 1'b0;
    assign unused_op_b = ^op_b;
`endif

    assign start_now  = (is_mul | is_div) & ~div_skip & (state_q == IDLE);
    assign unit_start = start_now;
    assign unit_op    = start_now ? op_code : UOP_MULT;
    assign busy       = (state_q == RUN);
    assign stall      = d_is_md & (busy | start_now);

    // mfhi/mflo read the committed registers directly.
    assign rd_data = is_mfhi ? hi_q :
                     is_mflo ? lo_q : 32'd0;

    // Next-state logic: launch, latency count, commit and mthi/mtlo writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_now) begin
                    state_d = RUN;
                    cnt_d   = is_div ? DIV_CNT : MULT_CNT;
                end else if (is_mthi) begin
                    hi_d = op_a;
                end else if (is_mtlo) begin
                    lo_d = op_a;
                end
            end
            RUN: begin
                // Anything arriving in E while running is ignored.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight without a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and randomized bench for md_sched with a behavioural
// HI/LO model and a behavioural mult/div unit.
module tb_md_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        d_is_md;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        unit_start;
    logic [1:0]  unit_op;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_type    (op_type),
        .op_a       (op_a),
        .op_b       (op_b),
        .d_is_md    (d_is_md),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .busy       (busy),
        .stall      (stall),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Arithmetic result {hi, lo} of a unit operation; divide by zero gives {a, all-ones}.
    function automatic logic [63:0] md_result(input logic [1:0] uop, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = 64'd0;
        case (uop)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Behavioural unit: results only valid from its last latency cycle on, junk before.
    logic [63:0] u_res  = 64'd0;
    logic [63:0] u_junk = 64'd0;
    int          u_age  = 1000;
    int          u_lat  = 1;

    always @(posedge clk) begin
        u_junk <= {$urandom, $urandom};
        if (unit_start) begin
            u_res <= md_result(unit_op, op_a, op_b);
            u_age <= 0;
            u_lat <= (unit_op < 2'd2) ? MULT_LAT : DIV_LAT;
        end else if (u_age < 1000) begin
            u_age <= u_age + 1;
        end
    end

    assign {res_hi, res_lo} = (u_age >= u_lat - 1) ? u_res : u_junk;

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin
        logic [31:0] m_hi, m_lo;
        logic [63:0] m_pend;
        int          m_left;
        logic        is_ar, is_dv, skip, e_start, e_busy, e_stall;
        logic [3:0]  tm1;
        logic [1:0]  e_uop;
        logic [31:0] e_rd;
        m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
            end
            is_ar = op_valid && op_type >= 4'd1 && op_type <= 4'd4;
            is_dv = op_type == 4'd3 || op_type == 4'd4;
            skip  = 1'b0;
`ifdef MD_DIV0_SKIP_EN
            skip  = is_dv && op_b == 32'd0;
`endif
            e_start = is_ar && m_left == 0 && !skip;
            tm1     = op_type - 4'd1;
            e_uop   = e_start ? tm1[1:0] : 2'd0;
            e_busy  = m_left > 0;
            e_stall = d_is_md && (e_busy || e_start);
            e_rd    = (op_valid && op_type == 4'd7) ? m_hi :
                      (op_valid && op_type == 4'd8) ? m_lo : 32'd0;
            check("unit_start", {31'd0, unit_start}, {31'd0, e_start});
            check("unit_op", {30'd0, unit_op}, {30'd0, e_uop});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("stall", {31'd0, stall}, {31'd0, e_stall});
            check("rd_data", rd_data, e_rd);
            if (!reset) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) {m_hi, m_lo} = m_pend;
                end else if (e_start) begin
                    m_left = is_dv ? DIV_LAT : MULT_LAT;
                    m_pend = md_result(tm1[1:0], op_a, op_b);
                end else if (op_valid && op_type == 4'd5) begin
                    m_hi = op_a;
                end else if (op_valid && op_type == 4'd6) begin
                    m_lo = op_a;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic d);
        op_valid = v; op_type = t; op_a = a; op_b = b; d_is_md = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        sample();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_start", {31'd0, unit_start}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        step();
        reset = 1'b0;

        // mult -1 * 2
        drive(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        sample();
        check("mul_start", {31'd0, unit_start}, 32'd1);
        check("mul_op", {30'd0, unit_op}, 32'd0);
        check("mul_busy0", {31'd0, busy}, 32'd0);
        step();
        for (int i = 1; i <= MULT_LAT; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            sample();
            check("mul_busy", {31'd0, busy}, 32'd1);
            step();
        end
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        sample();
        check("mul_busy_end", {31'd0, busy}, 32'd0);
        check("mul_hi", rd_data, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("mul_lo", rd_data, 32'hFFFF_FFFE);
        step();

        // divu 7 / 2 with a HI/LO instruction held in D
        drive(1'b1, 4'd4, 32'd7, 32'd2, 1'b1);
        sample();
        check("divu_stall0", {31'd0, stall}, 32'd1);
        check("divu_op", {30'd0, unit_op}, 32'd3);
        step();
        for (int i = 1; i <= DIV_LAT; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
            sample();
            check("divu_stall", {31'd0, stall}, 32'd1);
            step();
        end
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b1);
        sample();
        check("divu_stall_end", {31'd0, stall}, 32'd0);
        check("divu_hi", rd_data, 32'd1);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b1);
        sample();
        check("divu_lo", rd_data, 32'd3);
        step();

        // mthi from a clean reset
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
        sample();
        check("mthi_busy", {31'd0, busy}, 32'd0);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("mthi_lo", rd_data, 32'd0);
        check("mthi_busy1", {31'd0, busy}, 32'd0);
        step();
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        sample();
        check("mthi_hi", rd_data, 32'h1234_5678);
        step();

        // signed div -100 / 7, stray ops while running, D not HI/LO
        drive(1'b1, 4'd3, 32'hFFFF_FF9C, 32'd7, 1'b0);
        sample();
        check("div_stall0", {31'd0, stall}, 32'd0);
        step();
        for (int i = 1; i <= DIV_LAT; i++) begin
            if (i == 2) drive(1'b1, 4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
            else if (i == 3) drive(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
            else drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            sample();
            check("div_stall", {31'd0, stall}, 32'd0);
            if (i == 3) check("div_nostart", {31'd0, unit_start}, 32'd0);
            step();
        end
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("div_lo", rd_data, 32'hFFFF_FFF2);
        step();
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        sample();
        check("div_hi", rd_data, 32'hFFFF_FFFE);
        step();

        // reset in cycle 3 of a mult
        drive(1'b1, 4'd1, 32'd3, 32'd5, 1'b0);
        step();
        for (int i = 1; i <= 2; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            step();
        end
        reset = 1'b1;
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b1);
        sample();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_rd", rd_data, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            step();
        end
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("abort_lo", rd_data, 32'd0);
        step();
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        sample();
        check("abort_hi", rd_data, 32'd0);
        step();

        // div by zero
        drive(1'b1, 4'd3, 32'h0000_0055, 32'd0, 1'b1);
        sample();
`ifdef MD_DIV0_SKIP_EN
        check("div0_start", {31'd0, unit_start}, 32'd0);
        check("div0_stall", {31'd0, stall}, 32'd0);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("div0_busy", {31'd0, busy}, 32'd0);
        check("div0_lo", rd_data, 32'd0);
        step();
`else
        check("div0_start", {31'd0, unit_start}, 32'd1);
        check("div0_stall", {31'd0, stall}, 32'd1);
        step();
        for (int i = 1; i <= DIV_LAT; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            sample();
            check("div0_busy", {31'd0, busy}, 32'd1);
            step();
        end
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        sample();
        check("div0_hi", rd_data, 32'h0000_0055);
        step();
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        sample();
        check("div0_lo", rd_data, 32'hFFFF_FFFF);
        step();
`endif

        // randomized traffic, including ops while running and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  t;
            logic [31:0] a, b;
            t = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) != 0), t, a, b, 1'($urandom_range(0, 1)));
            step();
        end
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_sched.md
# md_sched

Controller for the HI/LO multiply/divide resource in the E stage of the P6 pipeline. Owns the architectural HI and LO registers, issues start pulses to an external multi-cycle mult/div arithmetic unit, counts its latency, and commits the unit's result into HI/LO on completion. Generates the D-stage stall for any HI/LO-touching instruction while an operation is in flight, and serves mfhi/mflo reads.

## Interface
Parameters:
- MULT_LAT, 5, cycles from accept to HI/LO commit for mult/multu (>=1)
- DIV_LAT, 10, cycles from accept to HI/LO commit for div/divu (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- op_valid  in  1  E-stage instruction is an HI/LO op
- op_type  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; others = none
- op_a  in  32  rs value (mthi/mtlo write data, unit operand A)
- op_b  in  32  rt value (unit operand B, div-by-zero check)
- d_is_md  in  1  D-stage instruction is any of op_type 1..8
- res_hi  in  32  unit high result (remainder for div)
- res_lo  in  32  unit low result (quotient for div)
- unit_start  out  1  one-cycle start to unit; unit samples op_a/op_b this cycle
- unit_op  out  2  0 mult, 1 multu, 2 div, 3 divu; valid when unit_start=1
- busy  out  1  operation in flight
- stall  out  1  hold D stage
- rd_data  out  32  mfhi -> HI, mflo -> LO, else 0

## Operation
- FSM states: IDLE, RUN. Down-counter cnt, 4 bits min (sized for max(MULT_LAT,DIV_LAT)-1).
- start_now = op_valid & op_type in 1..4 & state==IDLE (subject to Configuration).
- unit_start = start_now (combinational); unit_op = op_type-1 when start_now, else 0.
- IDLE + start_now: edge -> RUN, busy<=1, cnt<=LAT-1 (LAT by op class).
- RUN, cnt!=0: cnt<=cnt-1.
- RUN, cnt==0: HI<=res_hi, LO<=res_lo, busy<=0, -> IDLE. Unit must hold results valid this cycle.
- IDLE + mthi: HI<=op_a; mtlo: LO<=op_a. Single edge, no busy.
- Any op_valid while RUN: ignored (no start, no HI/LO write). Stall guarantees this never happens in-pipeline.
- stall = d_is_md & (busy | start_now). Non-HI/LO D instructions never stall.
- rd_data combinational from current HI/LO; mfhi/mflo in E cannot coincide with RUN.
- Reset values: HI=0, LO=0, busy=0, cnt=0, state=IDLE; hence unit_start=0, stall=0, rd_data=0 unless op_valid mfhi/mflo.
- Reset asserted mid-RUN: aborts immediately, no commit; unit result discarded.

## Timing
- Accept in cycle 0 -> busy=1 cycles 1..LAT -> HI/LO updated at end of cycle LAT, visible in cycle LAT+1.
- Back-to-back: new start accepted in cycle LAT+1 at earliest (IDLE again).
- stall high in cycle 0 (if d_is_md) and cycles 1..LAT; low in LAT+1.
- mthi/mtlo: written at end of accept cycle; mfhi immediately following sees new value.
- LAT=1: accept cycle 0, commit end of cycle 1.

## Configuration
- MD_DIV0_SKIP_EN defined: div/divu with op_b==0 is not started: unit_start=0, busy stays 0, HI/LO unchanged, stall not asserted by it; treated as a one-cycle no-op.
- Undefined: div/divu by zero starts normally, runs DIV_LAT cycles, commits whatever res_hi/res_lo the unit presents.

## Test plan
- Reset then mult, op_a=0xFFFFFFFF, op_b=2, unit model returns HI=0xFFFFFFFF LO=0xFFFFFFFE -> unit_start pulse cycle 0, unit_op=0, busy cycles 1..5, mfhi in cycle 6 reads 0xFFFFFFFF, mflo 0xFFFFFFFE.
- divu op_a=7, op_b=2, d_is_md=1 throughout -> busy/stall 10 cycles, then HI=1, LO=3; stall low cycle 11.
- mthi 0x12345678 then mflo/mfhi next cycles -> rd_data 0x00000000 for mflo, 0x12345678 for mfhi; busy never asserted.
- d_is_md=0 during a running div -> stall stays 0; op_valid mtlo while busy -> LO unchanged after commit (commit value only).
- Reset asserted cycle 3 of a mult -> busy=0, HI=LO=0 immediately, no later commit.
- div op_b=0: with MD_DIV0_SKIP_EN -> no unit_start, HI/LO unchanged, busy 0; without -> busy 10 cycles, commits unit values.
